// File: rtl/apb_top.sv
// APB3 subsystem: a master FSM that turns simple user requests into SETUP/ACCESS
// phases, and a register-file slave with optional wait states, joined by an internal bus.
`timescale 1ns/1ps
module apb_top #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  Transfer,
    input  logic                  Wr_Rd,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_psel;
    logic                  w_penable;
    logic                  w_pready;
    logic                  w_pslverr;
    logic                  w_done;
    logic                  w_capture;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] w_prdata;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign w_pslverr = 1'b0;
    assign w_pready  = (WAIT_STATES == 0) ? 1'b1 : (r_wait_cnt == WAIT_LAST);
    assign w_done    = w_psel & w_penable & w_pready;
    assign w_capture = (w_next_state == SETUP);
    assign read_data = r_read_data;

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_psel       = 1'b0;
        w_penable    = 1'b0;
        case (r_state)
            IDLE: begin
                if (Transfer) w_next_state = SETUP;
            end
            SETUP: begin
                w_psel       = 1'b1;
                w_next_state = ACCESS;
            end
            ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (w_pready) w_next_state = Transfer ? SETUP : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_state     <= IDLE;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_read_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_paddr  <= Address;
                r_pwrite <= Wr_Rd;
                r_pwdata <= write_data;
            end
            if (w_done && !r_pwrite && !w_pslverr) r_read_data <= w_prdata;
        end
    end

    // Counts stalled ACCESS cycles; any cycle that is not a stall clears it.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            r_wait_cnt <= '0;
        end else if (w_psel && w_penable && !w_pready) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign w_prdata = (w_psel && w_penable && !r_pwrite) ? r_mem[r_paddr] : '0;

    // NOTE: the memory is reset word-by-word because reset must zero its contents.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_done && r_pwrite && !w_pslverr) begin
            r_mem[r_paddr] <= r_pwdata;
        end
    end
endmodule

// File: tb/tb_apb_top.sv
// Directed bench for apb_top: a zero-wait instance and a two-wait-state instance,
// with read results checked by scoreboard monitors.
`timescale 1ns/1ps
module tb_apb_top;
    logic        clk = 1'b0;
    logic        rst0, transfer0, wr_rd0;
    logic [4:0]  address0;
    logic [31:0] write_data0, read_data0;
    logic        rst1, transfer1, wr_rd1;
    logic [4:0]  address1;
    logic [31:0] write_data1, read_data1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    apb_top #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESETn(rst0), .Transfer(transfer0), .Wr_Rd(wr_rd0),
        .Address(address0), .write_data(write_data0), .read_data(read_data0)
    );

    apb_top #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WAIT_STATES(2)) dut1 (
        .PCLK(clk), .PRESETn(rst1), .Transfer(transfer1), .Wr_Rd(wr_rd1),
        .Address(address1), .write_data(write_data1), .read_data(read_data1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one zero-wait transfer; returns just after the edge that enters ACCESS.
    task automatic issue0(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rd);
        @(negedge clk);
        transfer0   = 1'b1;
        wr_rd0      = wr;
        address0    = addr;
        write_data0 = data;
        if (!wr) q0.push_back(exp_rd);
        @(posedge clk); #1;
        check("setup_phase", {30'd0, dut0.w_psel, dut0.w_penable}, 32'd2);
        check("setup_paddr", {27'd0, dut0.r_paddr}, {27'd0, addr});
        @(posedge clk); #1;
        check("access_phase", {30'd0, dut0.w_psel, dut0.w_penable}, 32'd3);
        check("access_pwrite", {31'd0, dut0.r_pwrite}, {31'd0, wr});
    endtask

    task automatic finish0();
        @(negedge clk);
        transfer0   = 1'b0;
        write_data0 = 'x;
        @(posedge clk); #1;
        check("idle_after_access", {30'd0, dut0.w_psel, dut0.w_penable}, 32'd0);
    endtask

    // One transfer on the wait-state instance, counting ACCESS cycles.
    task automatic xfer1(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                         input logic [31:0] prev_rd, output int acc_cycles);
        bit done;
        @(negedge clk);
        transfer1   = 1'b1;
        wr_rd1      = wr;
        address1    = addr;
        write_data1 = data;
        if (!wr) q1.push_back(data);
        @(posedge clk); #1;
        check("ws_setup_phase", {30'd0, dut1.w_psel, dut1.w_penable}, 32'd2);
        @(negedge clk);
        transfer1   = 1'b0;
        write_data1 = 'x;
        address1    = 5'h00;
        acc_cycles  = 0;
        done        = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(posedge clk); #1;
            if (dut1.w_psel && dut1.w_penable) begin
                acc_cycles++;
                check("ws_paddr_stable", {27'd0, dut1.r_paddr}, {27'd0, addr});
                check("ws_rd_before_ready", read_data1, prev_rd);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) check("ws_access_timeout", 32'd0, 32'd1);
    endtask

    initial begin : mon0
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (dut0.w_psel && dut0.w_penable && dut0.w_pready && !dut0.r_pwrite) begin
                @(posedge clk); #1;
                if (q0.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd0_unexpected: got %h, expected no read", read_data0);
                end else begin
                    exp = q0.pop_front();
                    check("rd0_data", read_data0, exp);
                end
            end
        end
    end

    initial begin : mon1
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (dut1.w_psel && dut1.w_penable && dut1.w_pready && !dut1.r_pwrite) begin
                @(posedge clk); #1;
                if (q1.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rd1_unexpected: got %h, expected no read", read_data1);
                end else begin
                    exp = q1.pop_front();
                    check("rd1_data", read_data1, exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin : stim
        int acc;
        rst0 = 1'b1; transfer0 = 1'b0; wr_rd0 = 1'b0; address0 = '0; write_data0 = '0;
        rst1 = 1'b1; transfer1 = 1'b0; wr_rd1 = 1'b0; address1 = '0; write_data1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        check("reset_read_data", read_data0, 32'h0);
        check("reset_idle", {30'd0, dut0.w_psel, dut0.w_penable}, 32'd0);

        issue0(1'b0, 5'h03, 32'h0, 32'h0000_0000);
        finish0();

        issue0(1'b1, 5'h12, 32'hDEAD_BEEF, 32'h0);
        issue0(1'b0, 5'h12, 32'h0, 32'hDEAD_BEEF);
        finish0();

        issue0(1'b1, 5'h12, 32'hDEAD_BEEF, 32'h0);
        issue0(1'b1, 5'h15, 32'hDABB_CAFE, 32'h0);
        issue0(1'b0, 5'h12, 32'h0, 32'hDEAD_BEEF);
        issue0(1'b0, 5'h15, 32'h0, 32'hDABB_CAFE);
        finish0();

        repeat (3) begin
            @(negedge clk);
            write_data0 = 'x;
            check("idle_psel", {31'd0, dut0.w_psel}, 32'd0);
            check("idle_hold_read_data", read_data0, 32'hDABB_CAFE);
        end

        issue0(1'b0, 5'h15, 32'h0, 32'hDABB_CAFE);
        issue0(1'b0, 5'h12, 32'h0, 32'hDEAD_BEEF);
        issue0(1'b1, 5'h1F, 32'h0000_0001, 32'h0);
        issue0(1'b0, 5'h00, 32'h0, 32'h0000_0000);
        issue0(1'b0, 5'h1F, 32'h0, 32'h0000_0001);
        finish0();

        issue0(1'b1, 5'h07, 32'hA5A5_A5A5, 32'h0);
        @(negedge clk);
        rst0      = 1'b1;
        transfer0 = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_access_idle", {30'd0, dut0.w_psel, dut0.w_penable}, 32'd0);
        check("reset_mid_access_rd", read_data0, 32'h0);
        @(negedge clk);
        rst0 = 1'b0;
        issue0(1'b0, 5'h07, 32'h0, 32'h0000_0000);
        issue0(1'b0, 5'h12, 32'h0, 32'h0000_0000);
        finish0();

        xfer1(1'b1, 5'h15, 32'hDABB_CAFE, 32'h0, acc);
        check("ws_write_access_len", acc, 32'd3);
        xfer1(1'b0, 5'h15, 32'hDABB_CAFE, 32'h0, acc);
        check("ws_read_access_len", acc, 32'd3);

        repeat (4) @(posedge clk);
        #1;
        check("rd0_pending", q0.size(), 32'd0);
        check("rd1_pending", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_top.md
Name: apb_top

Overview:
- Self-contained APB subsystem that pairs an APB3 master with a single APB slave containing a register-file memory, connected by an internal APB bus.
- The user side issues simple transfer requests (Transfer, Wr_Rd, Address, write_data); the master converts each into APB SETUP/ACCESS phases, and the slave performs the write or returns read data.
- Used as a protocol demonstrator and as a bus-fabric building block.

Parameters:
ADDR_WIDTH, 5, width of Address/PADDR; memory depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, width of write_data/read_data/PWDATA/PRDATA
WAIT_STATES, 0, number of cycles the slave holds PREADY low in ACCESS before completing (0 = zero-wait)

Ports:
PCLK  input  1  system clock; all state updates on rising edge
PRESETn  input  1  synchronous, active-high reset: while 1 at a rising PCLK edge, all state is reset
Transfer  input  1  request a transfer; held high for back-to-back transfers
Wr_Rd  input  1  1 = write, 0 = read
Address  input  ADDR_WIDTH  target word address
write_data  input  DATA_WIDTH  data for write transfers
read_data  output  DATA_WIDTH  data from the last completed read

Behaviour:
- Reset (PRESETn=1 at a rising edge):
  - master FSM goes to IDLE
  - internal PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0
  - read_data=0
  - every memory word=0
  - wait-state counter=0
- Reset wins over any in-progress transfer; an aborted transfer has no effect on memory.
- Master FSM states:
  - IDLE: PSEL=0, PENABLE=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- Transitions, evaluated each rising edge:
  - IDLE -> SETUP if Transfer=1, else stay IDLE.
  - SETUP -> ACCESS unconditionally.
  - ACCESS with PREADY=0 -> stay ACCESS; PADDR, PWRITE and PWDATA are held stable.
  - ACCESS with PREADY=1 and Transfer=1 -> SETUP (back-to-back transfer).
  - ACCESS with PREADY=1 and Transfer=0 -> IDLE.
- Request capture: Address, Wr_Rd and write_data are registered into PADDR, PWRITE and PWDATA on the edge that enters SETUP. Changes to these inputs at any other time are ignored.
- Slave PREADY:
  - Only meaningful while PSEL&PENABLE.
  - With WAIT_STATES=0, PREADY=1 throughout ACCESS.
  - Otherwise PREADY=0 for the first WAIT_STATES ACCESS cycles, then 1. The counter clears on leaving ACCESS.
- Write: on the edge where PSEL&PENABLE&PREADY&PWRITE, mem[PADDR] <= PWDATA.
- Read:
  - PRDATA = mem[PADDR] combinationally while PSEL&PENABLE&~PWRITE, else 0.
  - The master loads read_data <= PRDATA on the edge where the read ACCESS completes (PREADY=1).
  - read_data holds its value through writes and idle periods.
- Latency (zero-wait), with Transfer first sampled high at edge E:
  - SETUP during cycle E..E+1, ACCESS during E+1..E+2.
  - A write is committed, or read_data updated, at edge E+2.
  - Back-to-back transfers take 2 cycles each.
- Every address in the full 0..2**ADDR_WIDTH-1 range is valid; there is no PSLVERR (it is tied 0 internally).
- If Transfer drops during SETUP, the transfer still completes, then the FSM returns to IDLE.
- X on write_data outside the capture edge has no effect.

Test Plan:
- Reset: assert PRESETn=1 for 2 cycles -> read_data=0, FSM IDLE; then a read of any address returns 0x00000000.
- Single write then read, Transfer held high: write 0xDEADBEEF to 0x12 -> mem[0x12]=0xDEADBEEF two edges after SETUP entry. Then read 0x12 -> read_data=0xDEADBEEF at ACCESS completion.
- Back-to-back writes with Transfer continuously high:
  - write 0xDEADBEEF @0x12, then 0xDABBCAFE @0x15 -> alternating SETUP/ACCESS with no IDLE between; both words stored.
  - Read 0x12 then 0x15 -> read_data = 0xDEADBEEF then 0xDABBCAFE, each 2 cycles apart.
- Transfer deasserted during ACCESS -> FSM enters IDLE, PSEL=0; read_data holds its last value; write_data=X during IDLE does not corrupt memory.
- WAIT_STATES=2: read 0x15 -> ACCESS lasts 3 cycles, PADDR stable throughout; read_data=0xDABBCAFE only after PREADY=1.
- Reset asserted mid-ACCESS of a write to 0x07 -> FSM IDLE, mem[0x07] remains 0.
